term_cursor_ctrl: RTL and testbench

Character-terminal write controller that sits directly upstream of the VGA text display. It accepts one ASCII code per handshake from the keyboard/decoder path and maintains the text cursor. It produces the video-memory write port (ascout, waddr, wren) and the scroll offset consumed by the display stage. It also performs the buffer-clear sweep after reset and on buffer overflow.

---
 rtl/term_pkg.sv | 33 +++
 rtl/term_addr_calc.sv | 25 ++
 rtl/term_cursor_ctrl.sv | 138 +++++++++++++
 tb/tb_term_cursor_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/term_pkg.sv
// ============================================================================
// Module  : term_pkg
// Brief   : Shared geometry, character codes and state encoding for the
//           terminal cursor controller.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package term_pkg;

    localparam int COLS      = 71;
    localparam int ROWS      = 30;
    localparam int BUF_ROWS  = 115;
    localparam int BUF_CELLS = BUF_ROWS * COLS;

    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [6:0]  LAST_ROW  = 7'(BUF_ROWS - 1);
    localparam logic [6:0]  VIS_ROWS  = 7'(ROWS);
    localparam logic [12:0] LAST_CELL = 13'(BUF_CELLS - 1);

    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_NUL = 8'h00;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/term_addr_calc.sv
// ============================================================================
// Module  : term_addr_calc
// Brief   : Combinational row*71+col using shift-add, 13-bit result.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module term_addr_calc (
    input  logic [6:0]  row,
    input  logic [6:0]  col,
    output logic [12:0] addr
);

    logic [12:0] row_ext;
    logic [12:0] col_ext;

    assign row_ext = {6'd0, row};
    assign col_ext = {6'd0, col};

    // 71 = 64 + 4 + 2 + 1
    assign addr = (row_ext << 6) + (row_ext << 2) + (row_ext << 1) + row_ext + col_ext;

endmodule

`default_nettype wire

// File: rtl/term_cursor_ctrl.sv
// ============================================================================
// Module  : term_cursor_ctrl
// Brief   : Terminal write controller: cursor tracking, video-memory writes,
//           scroll offset and buffer-clear sweep.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module term_cursor_ctrl
    import term_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [7:0]  ascout,
    output logic [12:0] waddr,
    output logic        wren,
    output logic [12:0] offset,
    output logic [6:0]  cur_row,
    output logic [6:0]  cur_col
);

    state_t      state, state_nxt;
    logic [12:0] clr_cnt, clr_cnt_nxt;
    logic [6:0]  row_nxt, col_nxt;
    logic [6:0]  wr_row, wr_col, off_row;
    logic [12:0] wr_addr, offset_nxt, waddr_nxt;
    logic [7:0]  ascout_nxt;
    logic        wren_nxt;
    logic        accept, is_print, is_bs, adv_row;

    assign accept   = char_valid && char_ready && (state == ST_IDLE);
    assign is_print = (char_in >= 8'h20) && (char_in <= 8'h7E);
    assign is_bs    = (char_in == CH_BS);

    // Backspace writes at the cell it moves back to; everything else at the cursor.
    assign wr_row = (is_bs && (cur_col == 7'd0)) ? cur_row - 7'd1 : cur_row;
    assign wr_col = is_bs ? ((cur_col != 7'd0) ? cur_col - 7'd1 : LAST_COL) : cur_col;

    assign off_row = (row_nxt >= VIS_ROWS) ? row_nxt - VIS_ROWS + 7'd1 : 7'd0;

    term_addr_calc u_wr_addr (
        .row  (wr_row),
        .col  (wr_col),
        .addr (wr_addr)
    );

    term_addr_calc u_off_addr (
        .row  (off_row),
        .col  (7'd0),
        .addr (offset_nxt)
    );

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        row_nxt     = cur_row;
        col_nxt     = cur_col;
        wren_nxt    = 1'b0;
        waddr_nxt   = waddr;
        ascout_nxt  = ascout;
        adv_row     = 1'b0;

        case (state)
            ST_CLEAR: begin
                wren_nxt   = 1'b1;
                waddr_nxt  = clr_cnt;
                ascout_nxt = CH_NUL;
                if (clr_cnt == LAST_CELL) begin
                    state_nxt   = ST_IDLE;
                    clr_cnt_nxt = 13'd0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 13'd1;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    if (is_print) begin
                        wren_nxt   = 1'b1;
                        waddr_nxt  = wr_addr;
                        ascout_nxt = char_in;
                        if (cur_col == LAST_COL) adv_row = 1'b1;
                        else                     col_nxt = cur_col + 7'd1;
                    end else if (char_in == CH_CR) begin
                        adv_row = 1'b1;
                    end else if (is_bs && ((cur_col != 7'd0) || (cur_row != 7'd0))) begin
                        wren_nxt   = 1'b1;
                        waddr_nxt  = wr_addr;
                        ascout_nxt = CH_SP;
                        row_nxt    = wr_row;
                        col_nxt    = wr_col;
                    end
                end
                if (adv_row) begin
                    col_nxt = 7'd0;
                    // Running off the last buffer row wipes the screen and homes the cursor.
                    if (cur_row == LAST_ROW) begin
                        row_nxt     = 7'd0;
                        state_nxt   = ST_CLEAR;
                        clr_cnt_nxt = 13'd0;
                    end else begin
                        row_nxt = cur_row + 7'd1;
                    end
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_CLEAR;
            clr_cnt    <= 13'd0;
            cur_row    <= 7'd0;
            cur_col    <= 7'd0;
            offset     <= 13'd0;
            wren       <= 1'b0;
            waddr      <= 13'd0;
            ascout     <= 8'd0;
            char_ready <= 1'b0;
        end else begin
            state      <= state_nxt;
            clr_cnt    <= clr_cnt_nxt;
            cur_row    <= row_nxt;
            cur_col    <= col_nxt;
            offset     <= offset_nxt;
            wren       <= wren_nxt;
            waddr      <= waddr_nxt;
            ascout     <= ascout_nxt;
            char_ready <= (state == ST_IDLE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_term_cursor_ctrl.sv
// ============================================================================
// Module  : tb_term_cursor_ctrl
// Brief   : Self-checking bench for term_cursor_ctrl with a cursor/buffer model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_term_cursor_ctrl;

    localparam int NCOLS  = 71;
    localparam int NROWS  = 30;
    localparam int NBROWS = 115;
    localparam int NCELLS = NCOLS * NBROWS;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [7:0]  ascout;
    logic [12:0] waddr;
    logic        wren;
    logic [12:0] offset;
    logic [6:0]  cur_row;
    logic [6:0]  cur_col;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_row, m_col, m_off, m_clr_addr;
    bit m_clearing, m_rdy;
    bit exp_wren;
    int exp_addr, exp_asc;

    term_cursor_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .ascout     (ascout),
        .waddr      (waddr),
        .wren       (wren),
        .offset     (offset),
        .cur_row    (cur_row),
        .cur_col    (cur_col)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic m_write(input int addr, input int ch);
        exp_wren = 1'b1;
        exp_addr = addr;
        exp_asc  = ch;
    endtask

    task automatic m_newline();
        m_col = 0;
        if (m_row == NBROWS - 1) begin
            m_row      = 0;
            m_clearing = 1'b1;
            m_clr_addr = 0;
        end else begin
            m_row++;
        end
    endtask

    task automatic m_edge(input bit r, input bit v, input int c);
        bit was_idle;
        if (r) begin
            m_row = 0; m_col = 0; m_off = 0;
            m_clearing = 1'b1; m_clr_addr = 0; m_rdy = 1'b0;
            exp_wren = 1'b0; exp_addr = 0; exp_asc = 0;
            return;
        end
        was_idle = !m_clearing;
        exp_wren = 1'b0;
        if (m_clearing) begin
            m_write(m_clr_addr, 0);
            m_clr_addr++;
            if (m_clr_addr == NCELLS) m_clearing = 1'b0;
        end else if (v && m_rdy) begin
            if (c >= 32 && c <= 126) begin
                m_write(m_row * NCOLS + m_col, c);
                m_col++;
                if (m_col == NCOLS) m_newline();
            end else if (c == 13) begin
                m_newline();
            end else if (c == 8) begin
                if (m_col > 0) begin
                    m_col--;
                    m_write(m_row * NCOLS + m_col, 32);
                end else if (m_row > 0) begin
                    m_row--;
                    m_col = NCOLS - 1;
                    m_write(m_row * NCOLS + m_col, 32);
                end
            end
        end
        m_rdy = was_idle;
        m_off = (m_row >= NROWS) ? (m_row - NROWS + 1) * NCOLS : 0;
    endtask

    // Drive one cycle, advance the model, then compare after the edge.
    task automatic step(input bit v, input logic [7:0] c, input bit r = 1'b0);
        rst = r; char_valid = v; char_in = c;
        @(posedge clk);
        m_edge(r, v, int'(c));
        #1;
        check("wren", wren, exp_wren);
        if (exp_wren) begin
            check("waddr", waddr, exp_addr);
            check("ascout", ascout, exp_asc);
        end
        check("cur_row", cur_row, m_row);
        check("cur_col", cur_col, m_col);
        check("offset", offset, m_off);
        check("char_ready", char_ready, m_rdy);
    endtask

    function automatic logic [7:0] rand_char();
        int r;
        r = $urandom_range(0, 99);
        if (r < 65)      return 8'($urandom_range(32, 126));
        else if (r < 78) return 8'h0D;
        else if (r < 93) return 8'h08;
        else             return 8'($urandom);
    endfunction

    initial begin
        rst = 1'b1; char_valid = 1'b0; char_in = 8'h00;

        repeat (3) step(1'b0, 8'h00, 1'b1);
        check("rst_waddr", waddr, 0);
        check("rst_ascout", ascout, 0);

        // Initial clear sweep with noise on the input side
        for (int i = 0; i < NCELLS; i++) step(1'($urandom), 8'($urandom));
        check("clear_last_waddr", waddr, NCELLS - 1);
        step(1'b0, 8'h00);
        check("ready_after_clear", char_ready, 1);
        check("no_write_after_clear", wren, 0);

        step(1'b1, 8'h41);
        check("A_waddr", waddr, 0);
        step(1'b1, 8'h42);
        check("B_waddr", waddr, 1);
        check("B_ascout", ascout, 8'h42);
        check("AB_col", cur_col, 2);

        step(1'b1, 8'h08);
        step(1'b1, 8'h08);
        for (int i = 0; i < 72; i++) step(1'b1, 8'($urandom_range(32, 126)));
        check("wrap_waddr", waddr, 71);
        check("wrap_row", cur_row, 1);
        check("wrap_col", cur_col, 1);

        step(1'b1, 8'h08);
        step(1'b1, 8'h08);
        check("bs_up_waddr", waddr, 70);
        check("bs_up_ascout", ascout, 8'h20);
        check("bs_up_row", cur_row, 0);
        check("bs_up_col", cur_col, 70);

        repeat (70) step(1'b1, 8'h08);
        step(1'b0, 8'h00);
        step(1'b1, 8'h08);
        check("bs_home_wren", wren, 0);
        check("bs_home_col", cur_col, 0);

        for (int i = 0; i < 30; i++) begin
            step(1'b1, 8'h0D);
            if (i == 28) check("offset_row29", offset, 0);
        end
        check("enter30_row", cur_row, 30);
        check("enter30_offset", offset, 71);

        repeat (84) step(1'b1, 8'h0D);
        check("row114", cur_row, 114);
        check("row114_offset", offset, 6035);

        // Overflow with char_valid held high throughout the sweep
        step(1'b1, 8'h0D);
        check("ovf_row", cur_row, 0);
        check("ovf_offset", offset, 0);
        step(1'b1, 8'h41);
        check("ovf_first_clear_waddr", waddr, 0);
        check("ovf_ready_low", char_ready, 0);
        for (int i = 1; i < NCELLS; i++) step(1'b1, 8'($urandom_range(32, 126)));
        step(1'b0, 8'h00);
        check("ovf_ready_back", char_ready, 1);
        check("ovf_cursor_col", cur_col, 0);

        for (int i = 0; i < 3000; i++) step($urandom_range(0, 9) != 0, rand_char());

        // Reset mid-IDLE, then mid-CLEAR, then let the sweep finish
        step(1'b1, 8'h41, 1'b1);
        for (int i = 0; i < 500; i++) step(1'b1, rand_char());
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < NCELLS + 1; i++) step(1'($urandom), rand_char());
        for (int i = 0; i < 200; i++) step(1'b1, rand_char());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
